// File: rtl/pixel_dispatcher_if.sv
// rtl/pixel_dispatcher_if.sv - depth-calculator request/done handshake plus outgoing pixel stream
interface pixel_dispatcher_if;
    logic        start;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [31:0] re_c;
    logic [31:0] im_c;
    logic        done;
    logic [23:0] color;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_color;

    modport master (
        output start, x, y, re_c, im_c, out_valid, out_color,
        input  done, color, out_ready
    );

    modport slave (
        input  start, x, y, re_c, im_c, out_valid, out_color,
        output done, color, out_ready
    );
endinterface

// File: rtl/pixel_dispatcher.sv
// rtl/pixel_dispatcher.sv - raster-scan pixel dispatcher; STREAM_MARKERS_EN adds out_sof/out_eol
module pixel_dispatcher #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int FRAC      = 16,
    parameter int COLOR_LAT = 1
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic signed [31:0] re_min,
    input  logic signed [31:0] im_max,
    input  logic signed [31:0] step,
    pixel_dispatcher_if.master px,
    output logic               busy,
    output logic               frame_done
`ifdef STREAM_MARKERS_EN
    ,
    output logic               out_sof,
    output logic               out_eol
`endif
);
    localparam int LAT_W = 8;

    if (WIDTH < 1 || WIDTH > 1024 || HEIGHT < 1 || HEIGHT > 512 ||
        FRAC < 0 || FRAC > 31 || COLOR_LAT < 0 || COLOR_LAT > 255) begin : g_bad_params
        $error("pixel_dispatcher: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_LAT, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [9:0]         x_q;
    logic [8:0]         y_q;
    logic signed [31:0] re_q, im_q, re_min_q, step_q;
    logic [23:0]        color_q;
    logic [LAT_W-1:0]   lat_cnt;
    logic               frame_done_q;

    logic accept, last_x, last_y, launch, capture;

    assign last_x = (x_q == 10'(WIDTH - 1));
    assign last_y = (y_q == 9'(HEIGHT - 1));
    assign accept = (state_q == S_OUT) && px.out_ready;
    // The frame_done cycle still counts as busy for frame_start purposes.
    assign launch = (state_q == S_IDLE) && frame_start && !frame_done_q;
    assign capture = ((state_q == S_WAIT) && px.done && (COLOR_LAT == 0)) ||
                     ((state_q == S_LAT) && (lat_cnt == '0));

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (launch) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (px.done) state_d = (COLOR_LAT == 0) ? S_OUT : S_LAT;
            S_LAT:   if (lat_cnt == '0) state_d = S_OUT;
            S_OUT:   if (px.out_ready) state_d = (last_x && last_y) ? S_IDLE : S_ISSUE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            re_q         <= '0;
            im_q         <= '0;
            re_min_q     <= '0;
            step_q       <= '0;
            color_q      <= '0;
            lat_cnt      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= accept && last_x && last_y;
            if (launch) begin
                re_min_q <= re_min;
                step_q   <= step;
                x_q      <= '0;
                y_q      <= '0;
                re_q     <= re_min;
                im_q     <= im_max;
            end
            if ((state_q == S_WAIT) && px.done) lat_cnt <= LAT_W'(COLOR_LAT - 1);
            else if (state_q == S_LAT)          lat_cnt <= lat_cnt - 1'b1;
            if (capture) color_q <= px.color;
            // Coordinates advance incrementally; 32-bit wrap is intended.
            if (accept) begin
                if (!last_x) begin
                    x_q  <= x_q + 10'd1;
                    re_q <= re_q + step_q;
                end else if (!last_y) begin
                    x_q  <= '0;
                    y_q  <= y_q + 9'd1;
                    re_q <= re_min_q;
                    im_q <= im_q - step_q;
                end
            end
        end
    end

    assign px.start     = (state_q == S_ISSUE);
    assign px.out_valid = (state_q == S_OUT);
    assign px.x         = x_q;
    assign px.y         = y_q;
    assign px.re_c      = re_q;
    assign px.im_c      = im_q;
    assign px.out_color = color_q;
    assign busy         = (state_q != S_IDLE);
    assign frame_done   = frame_done_q;

`ifdef STREAM_MARKERS_EN
    assign out_sof = (state_q == S_OUT) && (x_q == '0) && (y_q == '0);
    assign out_eol = (state_q == S_OUT) && last_x;
`endif
endmodule

// File: tb/tb_pixel_dispatcher.sv
// tb/tb_pixel_dispatcher.sv - randomized self-checking bench for pixel_dispatcher
module tb_pixel_dispatcher;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int LAT  = 1;
    localparam int NPIX = W * H;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [31:0] re_min, im_max, step;
    logic        busy, frame_done;
`ifdef STREAM_MARKERS_EN
    logic        out_sof, out_eol;
`endif

    pixel_dispatcher_if bus();

    pixel_dispatcher #(.WIDTH(W), .HEIGHT(H), .FRAC(16), .COLOR_LAT(LAT)) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .frame_start (frame_start),
        .re_min      (re_min),
        .im_max      (im_max),
        .step        (step),
        .px          (bus),
        .busy        (busy),
        .frame_done  (frame_done)
`ifdef STREAM_MARKERS_EN
        ,
        .out_sof     (out_sof),
        .out_eol     (out_eol)
`endif
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: coordinates come from x*step products, not running sums.
    logic [31:0] m_re [NPIX];
    logic [31:0] m_im [NPIX];
    logic [23:0] exp_col [NPIX];
    logic [31:0] obs_re [NPIX];
    logic [31:0] obs_im [NPIX];
    logic [23:0] obs_col [NPIX];
    int issue_idx = NPIX;
    int acc_idx   = NPIX;
    int frames_done = 0;
    int sof_cnt = 0, eol_cnt = 0;

    int color_mode = 0, dmin = 2, dmax = 2, ready_mode = 0;
    int hold_px = -1, hold_cnt = 0;
    bit spur_en = 0;

    function automatic void build_model(input logic [31:0] re0, input logic [31:0] im0,
                                        input logic [31:0] st);
        for (int k = 0; k < NPIX; k++) begin
            m_re[k] = re0 + 32'(k % W) * st;
            m_im[k] = im0 - 32'(k / W) * st;
        end
    endfunction

    // Depth-calculator and sink emulation; colour is valid only in its one legal cycle.
    initial begin
        int done_cd, col_cd;
        logic [23:0] cur_exp;
        done_cd = 0; col_cd = 0; cur_exp = '0;
        bus.done = 1'b0; bus.color = '0; bus.out_ready = 1'b0;
        forever begin
            @(posedge sysclk); #1;
            if (reset) begin
                done_cd = 0; col_cd = 0;
                bus.done = 1'b0; bus.out_ready = 1'b0;
                continue;
            end
            bus.done  = 1'b0;
            bus.color = ~cur_exp;
            if (col_cd > 0) begin
                col_cd--;
                if (col_cd == 0) bus.color = cur_exp;
            end
            if (done_cd > 0) begin
                done_cd--;
                if (done_cd == 0) begin
                    bus.done = 1'b1;
                    if (LAT == 0) bus.color = cur_exp;
                    else          col_cd = LAT;
                end
            end
            if (bus.start && issue_idx < NPIX) begin
                cur_exp = (color_mode == 0) ? 24'(issue_idx) : 24'($urandom);
                exp_col[issue_idx] = cur_exp;
                done_cd = 1 + dmin + int'($urandom_range(0, dmax - dmin));
            end
            if (spur_en && (bus.out_valid || !busy) && !bus.start && done_cd == 0 && col_cd == 0 &&
                $urandom_range(0, 2) == 0)
                bus.done = 1'b1;
            if (bus.out_valid && acc_idx == hold_px && hold_cnt > 0) begin
                bus.out_ready = 1'b0;
                hold_cnt--;
            end else begin
                bus.out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
    end

    // Compare process: every request and every presented pixel against the model.
    initial begin
        bit prev_hold;
        prev_hold = 0;
        forever begin
            @(negedge sysclk);
            if (reset) begin
                prev_hold = 0;
                continue;
            end
            if (bus.start) begin
                check("busy_on_start", 64'(busy), 64'd1);
                if (issue_idx >= NPIX) begin
                    check("extra_start", 64'(issue_idx), 64'(NPIX - 1));
                end else begin
                    check("start_before_accept", 64'(issue_idx), 64'(acc_idx));
                    check("req_x", 64'(bus.x), 64'(issue_idx % W));
                    check("req_y", 64'(bus.y), 64'(issue_idx / W));
                    check("req_re", 64'(bus.re_c), 64'(m_re[issue_idx]));
                    check("req_im", 64'(bus.im_c), 64'(m_im[issue_idx]));
                    obs_re[issue_idx] = bus.re_c;
                    obs_im[issue_idx] = bus.im_c;
                    issue_idx++;
                end
            end
            if (prev_hold) check("valid_held", 64'(bus.out_valid), 64'd1);
            prev_hold = bus.out_valid && !bus.out_ready;
            if (bus.out_valid) begin
                if (acc_idx >= NPIX) begin
                    check("extra_pixel", 64'(acc_idx), 64'(NPIX - 1));
                end else begin
                    check("out_color", 64'(bus.out_color), 64'(exp_col[acc_idx]));
                    check("out_x", 64'(bus.x), 64'(acc_idx % W));
                    check("out_re", 64'(bus.re_c), 64'(m_re[acc_idx]));
`ifdef STREAM_MARKERS_EN
                    check("out_sof", 64'(out_sof), 64'(acc_idx == 0));
                    check("out_eol", 64'(out_eol), 64'((acc_idx % W) == W - 1));
`endif
                    if (bus.out_ready) begin
`ifdef STREAM_MARKERS_EN
                        sof_cnt += int'(out_sof);
                        eol_cnt += int'(out_eol);
`endif
                        obs_col[acc_idx] = bus.out_color;
                        acc_idx++;
                    end
                end
            end else begin
`ifdef STREAM_MARKERS_EN
                check("sof_idle", 64'(out_sof), 64'd0);
                check("eol_idle", 64'(out_eol), 64'd0);
`endif
            end
            if (frame_done) begin
                frames_done++;
                check("done_after_last", 64'(acc_idx), 64'(NPIX));
                check("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    task automatic run_frame(input logic [31:0] r, input logic [31:0] i, input logic [31:0] s);
        build_model(r, i, s);
        issue_idx = 0; acc_idx = 0; sof_cnt = 0; eol_cnt = 0;
        @(posedge sysclk); #1;
        frame_start = 1'b1; re_min = r; im_max = i; step = s;
        @(posedge sysclk); #1;
        frame_start = 1'b0; re_min = $urandom; im_max = $urandom; step = $urandom;
    endtask

    task automatic wait_done(input bit mid);
        int n;
        n = 0;
        while (!frame_done && n < 3000) begin
            @(posedge sysclk); #1;
            n++;
            frame_start = mid && (n == 7 || n == 25);
            if (frame_start) begin
                re_min = $urandom; im_max = $urandom; step = $urandom;
            end
        end
        if (n >= 3000) begin
            check("frame_timeout", 64'd0, 64'd1);
        end else begin
            frame_start = 1'b1;
            @(posedge sysclk); #1;
            frame_start = 1'b0;
            check("restart_in_done_cycle_busy", 64'(busy), 64'd0);
            check("restart_in_done_cycle_start", 64'(bus.start), 64'd0);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; frame_start = 1'b0;
        re_min = '0; im_max = '0; step = '0;
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_start", 64'(bus.start), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_x", 64'(bus.x), 64'd0);
        check("rst_re", 64'(bus.re_c), 64'd0);
        check("rst_color", 64'(bus.out_color), 64'd0);
        reset = 1'b0;

        // -2.0 / 1.0 / 0.5 viewport, done 3 cycles after start, colour = pixel index
        color_mode = 0; dmin = 2; dmax = 2; ready_mode = 0;
        run_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000);
        wait_done(0);
        check("pin_re0", 64'(obs_re[0]), 64'h0000_0000_FFFE_0000);
        check("pin_re3", 64'(obs_re[3]), 64'h0000_0000_FFFF_8000);
        check("pin_im4", 64'(obs_im[4]), 64'h0000_0000_0000_8000);
        check("pin_col5", 64'(obs_col[5]), 64'd5);
        check("frames_a", 64'(frames_done), 64'd1);

        // random viewport, back-pressure, stall on pixel 2, spurious done, mid-frame frame_start
        color_mode = 1; dmin = 0; dmax = 3; ready_mode = 1; spur_en = 1;
        hold_px = 2; hold_cnt = 10;
        repeat (10) @(posedge sysclk);
        #1;
        run_frame($urandom, $urandom, $urandom);
        wait_done(1);
        spur_en = 0;
        check("frames_b", 64'(frames_done), 64'd2);
        check("pixels_b", 64'(acc_idx), 64'(NPIX));

        // reset while pixel 5 waits for done
        dmin = 3; dmax = 3; ready_mode = 0;
        run_frame($urandom, $urandom, $urandom);
        n = 0;
        while (issue_idx < 6 && n < 1000) begin
            @(posedge sysclk);
            n++;
        end
        check("reached_pixel5", 64'(issue_idx), 64'd6);
        #1 reset = 1'b1;
        #1;
        check("abort_start", 64'(bus.start), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_x", 64'(bus.x), 64'd0);
        check("abort_y", 64'(bus.y), 64'd0);
        check("abort_im", 64'(bus.im_c), 64'd0);
        repeat (2) @(posedge sysclk);
        #1 reset = 1'b0;
        check("abort_no_done", 64'(frames_done), 64'd2);

        // wrapping real axis, markers
        dmin = 0; dmax = 2; ready_mode = 1;
        run_frame(32'h7FFF_0000, 32'h0000_0000, 32'h0000_8000);
        wait_done(0);
        check("pin_wrap_re2", 64'(obs_re[2]), 64'h0000_0000_8000_0000);
        check("pin_wrap_re3", 64'(obs_re[3]), 64'h0000_0000_8000_8000);
        check("pin_wrap_im4", 64'(obs_im[4]), 64'h0000_0000_FFFF_8000);
        check("frames_d", 64'(frames_done), 64'd3);
`ifdef STREAM_MARKERS_EN
        check("sof_count", 64'(sof_cnt), 64'd1);
        check("eol_count", 64'(eol_cnt), 64'd2);
`endif
        repeat (3) @(posedge sysclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
